// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative mult/div unit with HI/LO registers (shift-add, restoring divide)
// Optional signed mult/div selected by op[2] when MULDIV_SIGNED_EN is defined.
module mult_div_unit #(
  parameter int N = 32
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic [2:0]   op,
  input  logic [N-1:0] inA,
  input  logic [N-1:0] inB,
  output logic         busy,
  output logic         done,
  output logic         div_by_zero,
  output logic [N-1:0] hi,
  output logic [N-1:0] lo
);

  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {IDLE, MULT, DIV, FINISH} state_t;

  state_t         state;
  logic [CW-1:0]  cnt;
  logic [N-1:0]   opnd;
  logic [N-1:0]   acc_hi;
  logic [N-1:0]   acc_lo;
  logic           is_div;
  logic           dz_pend;

  logic [N-1:0]   mag_a;
  logic [N-1:0]   mag_b;
  logic [N:0]     mul_sum;
  logic [N:0]     rem_sh;
  logic [N:0]     rem_diff;
  logic [2*N-1:0] prod_fix;
  logic [N-1:0]   quo_fix;
  logic [N-1:0]   rem_fix;

`ifdef MULDIV_SIGNED_EN
  logic sign_a;
  logic sign_b;
  logic neg_q;
  logic neg_r;

  assign sign_a = op[2] & inA[N-1];
  assign sign_b = op[2] & inB[N-1];
  assign mag_a  = sign_a ? -inA : inA;
  assign mag_b  = sign_b ? -inB : inB;

  // neg_q flips the product for mult and the quotient for div; remainder follows the dividend
  assign prod_fix = neg_q ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
  assign quo_fix  = neg_q ? -acc_lo : acc_lo;
  assign rem_fix  = neg_r ? -acc_hi : acc_hi;
`else
  logic unused_op_sign;

  assign unused_op_sign = op[2];
  assign mag_a    = inA;
  assign mag_b    = inB;
  assign prod_fix = {acc_hi, acc_lo};
  assign quo_fix  = acc_lo;
  assign rem_fix  = acc_hi;
`endif

  // Multiply: acc_hi:acc_lo holds partial product above the not-yet-consumed multiplier bits
  assign mul_sum  = {1'b0, acc_hi} + {1'b0, (acc_lo[0] ? opnd : {N{1'b0}})};
  // Divide: acc_hi is the running remainder, acc_lo shifts dividend out and quotient in
  assign rem_sh   = {acc_hi, acc_lo[N-1]};
  assign rem_diff = rem_sh - {1'b0, opnd};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      opnd        <= '0;
      acc_hi      <= '0;
      acc_lo      <= '0;
      is_div      <= 1'b0;
      dz_pend     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      hi          <= '0;
      lo          <= '0;
`ifdef MULDIV_SIGNED_EN
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            div_by_zero <= 1'b0;
            cnt         <= '0;
            dz_pend     <= 1'b0;
`ifdef MULDIV_SIGNED_EN
            neg_q       <= sign_a ^ sign_b;
            neg_r       <= sign_a;
`endif
            case (op[1:0])
              2'b00: begin
                opnd   <= mag_a;
                acc_hi <= '0;
                acc_lo <= mag_b;
                is_div <= 1'b0;
                busy   <= 1'b1;
                state  <= MULT;
              end
              2'b01: begin
                is_div <= 1'b1;
                busy   <= 1'b1;
                if (inB == '0) begin
                  // Raw dividend and all-ones quotient bypass sign correction
                  acc_hi  <= inA;
                  acc_lo  <= '1;
                  dz_pend <= 1'b1;
`ifdef MULDIV_SIGNED_EN
                  neg_q   <= 1'b0;
                  neg_r   <= 1'b0;
`endif
                  state   <= FINISH;
                end else begin
                  opnd   <= mag_b;
                  acc_hi <= '0;
                  acc_lo <= mag_a;
                  state  <= DIV;
                end
              end
              2'b10:   hi <= inA;
              default: lo <= inA;
            endcase
          end
        end
        MULT: begin
          acc_hi <= mul_sum[N:1];
          acc_lo <= {mul_sum[0], acc_lo[N-1:1]};
          cnt    <= cnt + 1'b1;
          if (cnt == CW'(N - 1)) state <= FINISH;
        end
        DIV: begin
          if (!rem_diff[N]) begin
            acc_hi <= rem_diff[N-1:0];
            acc_lo <= {acc_lo[N-2:0], 1'b1};
          end else begin
            acc_hi <= rem_sh[N-1:0];
            acc_lo <= {acc_lo[N-2:0], 1'b0};
          end
          cnt <= cnt + 1'b1;
          if (cnt == CW'(N - 1)) state <= FINISH;
        end
        default: begin
          hi          <= is_div ? rem_fix : prod_fix[2*N-1:N];
          lo          <= is_div ? quo_fix : prod_fix[N-1:0];
          div_by_zero <= dz_pend;
          done        <= 1'b1;
          busy        <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - directed self-checking bench for mult_div_unit (N=32)
module tb_mult_div_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op    = 3'b000;
  logic [31:0] inA   = '0;
  logic [31:0] inB   = '0;
  logic        busy;
  logic        done;
  logic        div_by_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  int tests = 0;
  int fails = 0;

  mult_div_unit #(.N(32)) dut (
    .clock(clock), .reset(reset), .start(start), .op(op), .inA(inA), .inB(inB),
    .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input int exp_cyc, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo, input logic exp_dz, input bit poke);
    logic [31:0] hi0;
    int cyc;
    bit seen;
    @(negedge clock);
    hi0 = hi;
    op = o; inA = a; inB = b; start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0; inA = ~a; inB = ~b;
    cyc = 0; seen = 0;
    while (cyc < 100 && !seen) begin
      @(negedge clock);
      cyc++;
      start = 1'b0;
      if (cyc == 1) check({tag, "_busy"}, busy, 1'b1);
      if (cyc == 3 && exp_cyc > 3) check({tag, "_hi_hold"}, hi, hi0);
      if (poke && cyc == 5) begin
        start = 1'b1; op = 3'b010; inA = 32'h0BAD_0BAD;
      end
      if (done) seen = 1;
    end
    start = 1'b0;
    check({tag, "_cycles"}, cyc, exp_cyc);
    check({tag, "_hi"}, hi, exp_hi);
    check({tag, "_lo"}, lo, exp_lo);
    check({tag, "_dz"}, div_by_zero, exp_dz);
    @(negedge clock);
    check({tag, "_done_pulse"}, done, 1'b0);
  endtask

  initial begin
    int cyc, first, second, ndone;

    #12;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_dz", div_by_zero, 1'b0);
    check("rst_hi", hi, 32'h0);
    check("rst_lo", lo, 32'h0);
    @(negedge clock);
    reset = 1'b0;

    run_op("mult_ff", 3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 0);
    run_op("mult_sh", 3'b000, 32'h1234_5678, 32'h0000_0010, 34, 32'h0000_0001, 32'h2345_6780, 1'b0, 0);
    run_op("divu_100_7", 3'b001, 32'd100, 32'd7, 34, 32'd2, 32'd14, 1'b0, 1);
    run_op("divu_5_9", 3'b001, 32'd5, 32'd9, 34, 32'd5, 32'd0, 1'b0, 0);
    run_op("divu_zero", 3'b001, 32'h0000_1234, 32'h0, 2, 32'h0000_1234, 32'hFFFF_FFFF, 1'b1, 0);

    @(negedge clock);
    op = 3'b010; inA = 32'hDEAD_BEEF; start = 1'b1;
    @(posedge clock);
    #1;
    check("mthi_hi", hi, 32'hDEAD_BEEF);
    check("mthi_dz_clr", div_by_zero, 1'b0);
    check("mthi_busy", busy, 1'b0);
    op = 3'b011; inA = 32'h0000_0005;
    @(posedge clock);
    #1;
    start = 1'b0;
    check("mtlo_lo", lo, 32'h0000_0005);
    check("mtlo_hi", hi, 32'hDEAD_BEEF);
    check("mtlo_busy", busy, 1'b0);
    check("mtlo_done", done, 1'b0);

`ifdef MULDIV_SIGNED_EN
    run_op("div_m7_2", 3'b101, 32'hFFFF_FFF9, 32'd2, 34, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 0);
    run_op("mult_m3_4", 3'b100, 32'hFFFF_FFFD, 32'd4, 34, 32'hFFFF_FFFF, 32'hFFFF_FFF4, 1'b0, 0);
    run_op("div_ovf", 3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 34, 32'h0, 32'h8000_0000, 1'b0, 0);
`else
    run_op("multu_op2", 3'b100, 32'hFFFF_FFFD, 32'd4, 34, 32'h0000_0003, 32'hFFFF_FFF4, 1'b0, 0);
`endif

    // start held high: successive dones should be N+2 cycles apart
    @(negedge clock);
    op = 3'b000; inA = 32'd3; inB = 32'd5; start = 1'b1;
    cyc = 0; first = -1; second = -1;
    while (cyc < 200 && second < 0) begin
      @(negedge clock);
      cyc++;
      if (done) begin
        if (first < 0) first = cyc;
        else second = cyc;
      end
    end
    start = 1'b0;
    check("b2b_gap", second - first, 34);
    check("b2b_lo", lo, 32'd15);
    repeat (3) @(negedge clock);

    // reset mid-multiply aborts with no later done
    @(negedge clock);
    op = 3'b000; inA = 32'hFFFF_FFFF; inB = 32'hFFFF_FFFF; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (9) @(negedge clock);
    reset = 1'b1;
    #1;
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_hi", hi, 32'h0);
    check("abort_lo", lo, 32'h0);
    @(negedge clock);
    reset = 1'b0;
    ndone = 0;
    repeat (50) begin
      @(negedge clock);
      if (done) ndone++;
    end
    check("abort_no_done", ndone, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
